// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF transmit scheduler.
package spdif_pkg;

    localparam int SPDIF_SUBFRAME_CYCLES = 64;
    localparam int SPDIF_BLOCK_FRAMES    = 192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_sample_t;

endpackage

// File: rtl/spdif_sample_fifo.sv
// Small synchronous FIFO of stereo PCM pairs. Pop on empty and push on full
// are ignored; the head entry is always visible on dout.
module spdif_sample_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  stereo_sample_t din,
    input  logic           pop,
    output stereo_sample_t dout,
    output logic [LW-1:0]  level,
    output logic           full,
    output logic           empty
);

    stereo_sample_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spdif_sched.sv
// S/PDIF scheduler: buffers PCM pairs and emits alternating left/right words,
// one strobe per subframe slot, tracking block position and underruns.
module spdif_sched
    import spdif_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int SUBFRAME_CYCLES = SPDIF_SUBFRAME_CYCLES,
    parameter int BLOCK_FRAMES    = SPDIF_BLOCK_FRAMES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                mute,
    input  logic [15:0]                         in_left,
    input  logic [15:0]                         in_right,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [15:0]                         tx_data,
    output logic                                tx_valid,
    output logic                                block_start,
    output logic [7:0]                          frame_idx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic [7:0]                          underrun_cnt,
    input  logic                                underrun_clr,
    output logic                                busy
);

    localparam int SW = $clog2(SUBFRAME_CYCLES);

    sched_state_t   state;
    logic [SW-1:0]  slot;
    logic           slot_last;
    logic [15:0]    hold;
    logic           rst_q;
    logic           fifo_full;
    logic           fifo_empty;
    stereo_sample_t head;
    stereo_sample_t in_pair;
    logic [7:0]     frame_nxt;
    logic [7:0]     left_frame;
    logic           enter_left;
    logic           push;
    logic           pop;
    logic           underrun;

    assign slot_last  = (slot == SW'(SUBFRAME_CYCLES - 1));
    assign frame_nxt  = (frame_idx == 8'(BLOCK_FRAMES - 1)) ? 8'd0 : frame_idx + 8'd1;
    // A new left subframe starts either from IDLE or at the end of RIGHT.
    assign enter_left = !rst && enable && ((state == IDLE) || (state == RIGHT && slot_last));
    assign left_frame = (state == IDLE) ? 8'd0 : frame_nxt;
    assign pop        = enter_left && !fifo_empty;
    assign underrun   = enter_left && fifo_empty;
    // Ready depends on level only, so a same-cycle pop never raises it.
    assign in_ready   = !rst_q && !fifo_full;
    assign push       = in_valid && in_ready;
    assign in_pair    = '{l: in_left, r: in_right};
    assign busy       = (state != IDLE);

    spdif_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_pair),
        .pop   (pop),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Delayed reset keeps in_ready low on the cycle right after reset.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Subframe sequencing: strobe and data are registered on entry to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            frame_idx   <= '0;
            hold        <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            block_start <= 1'b0;
        end else begin
            tx_valid    <= 1'b0;
            block_start <= 1'b0;
            if (enter_left) begin
                state       <= LEFT;
                slot        <= '0;
                frame_idx   <= left_frame;
                tx_valid    <= 1'b1;
                block_start <= (left_frame == 8'd0);
                tx_data     <= (fifo_empty || mute) ? 16'd0 : head.l;
                hold        <= (fifo_empty || mute) ? 16'd0 : head.r;
            end else begin
                case (state)
                    LEFT: begin
                        if (slot_last) begin
                            state    <= RIGHT;
                            slot     <= '0;
                            tx_valid <= 1'b1;
                            tx_data  <= hold;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    RIGHT: begin
                        if (slot_last) begin
                            state     <= IDLE;
                            slot      <= '0;
                            frame_idx <= frame_nxt;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    default: slot <= '0;
                endcase
            end
        end
    end

    // Saturating underrun counter; a clear coinciding with an underrun leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun_clr) begin
            underrun_cnt <= underrun ? 8'd1 : 8'd0;
        end else if (underrun && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spdif_sched.sv
// Scoreboard bench for spdif_sched: stimulus queues expected strobes with
// their cycle numbers; a negedge monitor pops and compares each strobe.
module tb_spdif_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        block_start;
    logic [7:0]  frame_idx;
    logic [2:0]  fifo_level;
    logic [7:0]  underrun_cnt;
    logic        underrun_clr = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] d;
        logic        bs;
        int          c;
    } exp_t;

    exp_t q[$];

    spdif_sched dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mute         (mute),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .block_start  (block_start),
        .frame_idx    (frame_idx),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded: cyc advances every tick.
    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic exp_frame(input int c, input logic [15:0] l, input logic [15:0] r, input logic bs);
        exp_t e;
        e.d = l; e.bs = bs; e.c = c;
        q.push_back(e);
        e.d = r; e.bs = 1'b0; e.c = c + 64;
        q.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_tx_valid"},    32'(tx_valid), 32'd0);
        chk({tag, "_tx_data"},     32'(tx_data), 32'd0);
        chk({tag, "_block_start"}, 32'(block_start), 32'd0);
        chk({tag, "_frame_idx"},   32'(frame_idx), 32'd0);
        chk({tag, "_level"},       32'(fifo_level), 32'd0);
        chk({tag, "_underrun"},    32'(underrun_cnt), 32'd0);
        chk({tag, "_busy"},        32'(busy), 32'd0);
        chk({tag, "_in_ready"},    32'(in_ready), 32'd0);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        in_left = l; in_right = r; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(tx_data), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.c));
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("block_start", 32'(block_start), 32'(e.bs));
            end
        end else if (!rst && block_start === 1'b1) begin
            chk("block_start_no_valid", 32'(block_start), 32'd0);
        end
    end

    initial begin
        int c;

        // Reset state
        tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // First frame timing, drop enable 10 cycles into LEFT
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h1111, 16'h2222);
        chk("preload_level", 32'(fifo_level), 32'd2);
        c = cyc + 1;
        exp_frame(c, 16'h1234, 16'hABCD, 1'b1);
        enable = 1'b1;
        tick();
        chk("level_after_pop", 32'(fifo_level), 32'd1);
        tick(10);
        enable = 1'b0;
        wait_until(c + 127);
        chk("busy_last_slot", 32'(busy), 32'd1);
        wait_until(c + 128);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("frame_idx_after_stop", 32'(frame_idx), 32'd1);
        chk("level_kept", 32'(fifo_level), 32'd1);

        // Full FIFO backpressure, pushes resume after the left pop
        rst = 1'b1; tick(); rst = 1'b0; tick();
        push_pair(16'hA000, 16'hA001);
        push_pair(16'hB000, 16'hB001);
        push_pair(16'hC000, 16'hC001);
        push_pair(16'hD000, 16'hD001);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_left = 16'hE000; in_right = 16'hE001; in_valid = 1'b1;
        c = cyc + 1;
        exp_frame(c,       16'hA000, 16'hA001, 1'b1);
        exp_frame(c + 128, 16'hB000, 16'hB001, 1'b0);
        exp_frame(c + 256, 16'hC000, 16'hC001, 1'b0);
        exp_frame(c + 384, 16'hD000, 16'hD001, 1'b0);
        exp_frame(c + 512, 16'hE000, 16'hE001, 1'b0);
        enable = 1'b1;
        tick();
        chk("pop_full_level", 32'(fifo_level), 32'd3);
        chk("pop_full_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("refill_level", 32'(fifo_level), 32'd4);
        wait_until(c + 520);
        enable = 1'b0;
        wait_until(c + 640);
        chk("fill_busy", 32'(busy), 32'd0);
        chk("fill_level", 32'(fifo_level), 32'd0);
        chk("fill_underrun", 32'(underrun_cnt), 32'd0);
        chk("fill_frame_idx", 32'(frame_idx), 32'd5);

        // Underrun with a push landing in the pop cycle
        in_left = 16'h5555; in_right = 16'h6666; in_valid = 1'b1;
        c = cyc + 1;
        exp_frame(c,       16'h0000, 16'h0000, 1'b1);
        exp_frame(c + 128, 16'h5555, 16'h6666, 1'b0);
        enable = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("underrun_one", 32'(underrun_cnt), 32'd1);
        chk("underrun_push_level", 32'(fifo_level), 32'd1);
        wait_until(c + 130);
        enable = 1'b0;
        wait_until(c + 256);
        chk("underrun_idle_busy", 32'(busy), 32'd0);
        chk("underrun_still_one", 32'(underrun_cnt), 32'd1);

        // Mute, then reset mid-RIGHT
        push_pair(16'h7FFF, 16'h8000);
        mute = 1'b1;
        c = cyc + 1;
        exp_frame(c, 16'h0000, 16'h0000, 1'b1);
        enable = 1'b1;
        tick();
        mute = 1'b0;
        enable = 1'b0;
        chk("mute_level", 32'(fifo_level), 32'd0);
        wait_until(c + 70);
        rst = 1'b1;
        tick();
        check_cleared("mid_reset");
        rst = 1'b0;
        tick();

        // Long run on an empty FIFO: block wrap and counter saturation
        c = cyc + 1;
        for (int f = 0; f < 300; f++)
            exp_frame(c + 128 * f, 16'h0000, 16'h0000, (f % 192) == 0);
        enable = 1'b1;
        tick();
        wait_until(c + 127);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("clr_with_underrun", 32'(underrun_cnt), 32'd1);
        wait_until(c + 128 * 191);
        chk("frame_idx_191", 32'(frame_idx), 32'd191);
        wait_until(c + 128 * 192);
        chk("frame_idx_wrap", 32'(frame_idx), 32'd0);
        wait_until(c + 128 * 299 + 5);
        enable = 1'b0;
        wait_until(c + 128 * 300);
        chk("long_busy", 32'(busy), 32'd0);
        chk("underrun_sat", 32'(underrun_cnt), 32'd255);
        chk("long_frame_idx", 32'(frame_idx), 32'd108);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("underrun_cleared", 32'(underrun_cnt), 32'd0);

        tick(10);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spdif_sched.md
Name: spdif_sched

Overview:
- Sequences the S/PDIF transmitter: buffers stereo PCM pairs from the audio source (SPU mixer) in a small FIFO.
- Paces them out as alternating left/right 16-bit words with a one-cycle valid strobe, one word per subframe slot.
- Tracks the 192-frame block position, and mutes and counts underruns when the source falls behind.
- Sits between the audio source and the spdif transmitter in the HDMI audio path.

Parameters:
FIFO_DEPTH, 4, stereo pairs buffered (power of 2, >=2)
SUBFRAME_CYCLES, 64, clk cycles per subframe slot (8 preamble + 28 bits x 2 half-cells)
BLOCK_FRAMES, 192, frames per S/PDIF block

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
enable  in  1  run scheduler; sampled every cycle
mute  in  1  send zeros instead of sample data; FIFO still drains
in_left  in  16  left PCM sample
in_right  in  16  right PCM sample
in_valid  in  1  pair offered
in_ready  out  1  FIFO can accept pair
tx_data  out  16  word to transmitter
tx_valid  out  1  one-cycle strobe to transmitter
block_start  out  1  high with tx_valid of left subframe of frame 0
frame_idx  out  8  current frame index, 0..BLOCK_FRAMES-1
fifo_level  out  $clog2(FIFO_DEPTH+1)  pairs stored
underrun_cnt  out  8  saturating underrun count
underrun_clr  in  1  clear underrun_cnt
busy  out  1  state != IDLE

Behaviour:
- Reset (clk edge with rst=1):
  - state IDLE, FIFO empty, slot counter 0, frame_idx 0, underrun_cnt 0, hold register 0.
  - All outputs 0, including in_ready. rst overrides every other input.
- FIFO push:
  - in_ready = !rst_q && (fifo_level < FIFO_DEPTH). Combinational from level only, so a same-cycle pop does not raise it.
  - Push occurs when in_valid && in_ready; this holds in IDLE as well.
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE -> LEFT: enable sampled 1. The next cycle is slot 0 of LEFT with frame_idx 0.
  - LEFT -> RIGHT: slot counter = SUBFRAME_CYCLES-1.
  - RIGHT -> LEFT: slot counter = SUBFRAME_CYCLES-1 and enable = 1.
  - RIGHT -> IDLE: slot counter = SUBFRAME_CYCLES-1 and enable = 0.
  - Deasserting enable during LEFT never truncates a frame: the right subframe is always emitted.
- Slot counter: 0..SUBFRAME_CYCLES-1, wraps. It is held at 0 in IDLE.
- Outputs are registered.
  - tx_valid = 1 exactly in slot 0 of LEFT and of RIGHT, and 0 otherwise.
  - The first pulse is 1 cycle after enable is sampled in IDLE; pulses then follow every SUBFRAME_CYCLES cycles.
- Left slot 0:
  - If FIFO non-empty: pop one pair. tx_data = mute ? 0 : left; hold register <= mute ? 0 : right.
  - If FIFO empty: tx_data = 0, hold <= 0, and underrun_cnt increments, saturating at 255. Popping an empty FIFO is an underrun even if a push lands in the same cycle (no bypass); the pushed pair is used next frame.
- Right slot 0: tx_data = hold. A pair is never split across frames.
- tx_data holds its value between strobes.
- frame_idx increments at the end of RIGHT, wrapping BLOCK_FRAMES-1 -> 0.
- block_start = tx_valid && state==LEFT && frame_idx==0.
- Simultaneous push and pop: level unchanged, both pairs kept in order.
- underrun_clr: clears the count. If an underrun occurs in the same cycle, the count becomes 1.
- Re-enable after IDLE: frame_idx restarts at 0. FIFO contents are retained.

Decomposition:
- spdif_pkg holds:
  - sched_state_t enum {IDLE, LEFT, RIGHT}
  - stereo_sample_t struct {logic [15:0] l, r}
  - constants SPDIF_SUBFRAME_CYCLES = 64 and SPDIF_BLOCK_FRAMES = 192
- One sub-module: spdif_sample_fifo, a synchronous FIFO of stereo_sample_t with push, pop, level, full and empty. It ignores pop when empty.

Test Plan:
- Reset then enable=1 with FIFO preloaded with (L=0x1234,R=0xABCD) -> tx_valid at +1 cycle with tx_data=0x1234, at +65 with 0xABCD, block_start=1 on the first pulse only.
- Preload 4 pairs, hold in_valid=1 -> in_ready=0 while level=4; pushes resume after the left pop; 5th pair emitted as frame 4 in order.
- Enable with empty FIFO -> left and right words 0, underrun_cnt=1; a push in the pop cycle is emitted next frame, not this frame.
- Run 193 frames -> frame_idx wraps 191->0; block_start pulses on frames 0 and 192 only; 300 underruns -> underrun_cnt saturates at 255; underrun_clr -> 0.
- Drop enable 10 cycles into LEFT -> right word still emitted at slot 0 of RIGHT, IDLE after cycle 127, busy=0, FIFO level preserved.
- mute=1 with pair (0x7FFF,0x8000) queued -> both words 0 and FIFO level decrements; assert rst mid-RIGHT -> next cycle all outputs 0, state IDLE.
